// File: rtl/adc_conversor_arbiter_if.sv
// adc_conversor_arbiter_if
// Bundles the per-channel ADC strobes, the shared-conversor hookup and the
// tagged output stream of adc_conversor_arbiter.
//   slave  : the arbiter side (takes ADC samples, drives the stream)
//   master : the surrounding logic (ADC capture, conversor, downstream sink)
// Signals:
//   i_enable                  accept ADC samples when 1
//   i_ch1_data / i_ch1_valid  ch1 raw sample and single-cycle strobe
//   i_ch2_data / i_ch2_valid  ch2 raw sample and single-cycle strobe
//   o_conv_data / i_conv_data shared conversor input / output
//   o_data / o_channel        converted sample and its channel (0 = ch1)
//   o_valid / i_ready         output stream handshake
//   o_overrun_ch1/ch2         saturating dropped-sample counters
//   o_busy                    any sample pending or held on the output
interface adc_conversor_arbiter_if #(
  parameter int CONVERSOR_DATA_SIZE = 14,
  parameter int OVERRUN_CNT_SIZE    = 16
);
  logic                           i_enable;
  logic [CONVERSOR_DATA_SIZE-1:0] i_ch1_data;
  logic                           i_ch1_valid;
  logic [CONVERSOR_DATA_SIZE-1:0] i_ch2_data;
  logic                           i_ch2_valid;
  logic [CONVERSOR_DATA_SIZE-1:0] o_conv_data;
  logic [CONVERSOR_DATA_SIZE-1:0] i_conv_data;
  logic [CONVERSOR_DATA_SIZE-1:0] o_data;
  logic                           o_channel;
  logic                           o_valid;
  logic                           i_ready;
  logic [OVERRUN_CNT_SIZE-1:0]    o_overrun_ch1;
  logic [OVERRUN_CNT_SIZE-1:0]    o_overrun_ch2;
  logic                           o_busy;

  modport slave (
    input  i_enable, i_ch1_data, i_ch1_valid, i_ch2_data, i_ch2_valid,
    input  i_conv_data, i_ready,
    output o_conv_data, o_data, o_channel, o_valid,
    output o_overrun_ch1, o_overrun_ch2, o_busy
  );

  modport master (
    output i_enable, i_ch1_data, i_ch1_valid, i_ch2_data, i_ch2_valid,
    output i_conv_data, i_ready,
    input  o_conv_data, o_data, o_channel, o_valid,
    input  o_overrun_ch1, o_overrun_ch2, o_busy
  );
endinterface

// File: rtl/adc_conversor_arbiter.sv
// adc_conversor_arbiter
// Shares one data_conversor between two ADC channels. Each channel has a
// one-entry holding buffer; a round-robin arbiter pushes one pending sample
// per clock through the conversor and registers the result onto a single
// valid/ready stream tagged with its channel. Samples that arrive while the
// buffer is still occupied overwrite it and bump a saturating overrun count.
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  asynchronous active-low reset
//   bus      adc_conversor_arbiter_if.slave (samples, conversor, stream)
module adc_conversor_arbiter #(
  parameter int CONVERSOR_DATA_SIZE = 14,
  parameter int OVERRUN_CNT_SIZE    = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  adc_conversor_arbiter_if.slave  bus
);

  localparam int W = CONVERSOR_DATA_SIZE;
  localparam int C = OVERRUN_CNT_SIZE;

  function automatic logic [C-1:0] sat_inc(input logic [C-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic         pend1, pend2;
  logic [W-1:0] hold1, hold2;
  logic [C-1:0] ovr1, ovr2;
  logic         last_ch2;
  logic         gnt1, gnt2, out_free;
  logic [W-1:0] data_p0;
  logic         chan_p0;
  logic         vld_p0;

  // Arbitration: a grant consumes the output register, so it is only issued
  // when that register is empty or being drained this cycle.
  always_comb begin
    gnt1     = 1'b0;
    gnt2     = 1'b0;
    out_free = !vld_p0 || bus.i_ready;
    if (out_free) begin
      if (pend1 && pend2) begin
        if (last_ch2) gnt1 = 1'b1;
        else          gnt2 = 1'b1;
      end else begin
        gnt1 = pend1;
        gnt2 = pend2;
      end
    end
  end

  assign bus.o_conv_data = gnt1 ? hold1 : (gnt2 ? hold2 : '0);

  // ch1 holding buffer. A strobe on the granted cycle refills the buffer
  // without counting as an overrun; disabling flushes whatever is pending.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      pend1 <= 1'b0;
      hold1 <= '0;
      ovr1  <= '0;
    end else if (!bus.i_enable) begin
      pend1 <= 1'b0;
    end else if (bus.i_ch1_valid) begin
      pend1 <= 1'b1;
      hold1 <= bus.i_ch1_data;
      if (pend1 && !gnt1) ovr1 <= sat_inc(ovr1);
    end else if (gnt1) begin
      pend1 <= 1'b0;
    end
  end

  // ch2 holding buffer, same policy as ch1.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      pend2 <= 1'b0;
      hold2 <= '0;
      ovr2  <= '0;
    end else if (!bus.i_enable) begin
      pend2 <= 1'b0;
    end else if (bus.i_ch2_valid) begin
      pend2 <= 1'b1;
      hold2 <= bus.i_ch2_data;
      if (pend2 && !gnt2) ovr2 <= sat_inc(ovr2);
    end else if (gnt2) begin
      pend2 <= 1'b0;
    end
  end

  // Round-robin pointer: starts as "last = ch2" so ch1 wins the first tie.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)          last_ch2 <= 1'b1;
    else if (gnt1 || gnt2) last_ch2 <= gnt2;
  end

  // Output stage: conversor result captured on grant, held under backpressure.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      data_p0 <= '0;
      chan_p0 <= 1'b0;
      vld_p0  <= 1'b0;
    end else if (gnt1 || gnt2) begin
      data_p0 <= bus.i_conv_data;
      chan_p0 <= gnt2;
      vld_p0  <= 1'b1;
    end else if (bus.i_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign bus.o_data        = data_p0;
  assign bus.o_channel     = chan_p0;
  assign bus.o_valid       = vld_p0;
  assign bus.o_overrun_ch1 = ovr1;
  assign bus.o_overrun_ch2 = ovr2;
  assign bus.o_busy        = pend1 || pend2 || vld_p0;

endmodule

// File: tb/tb_adc_conversor_arbiter.sv
// Directed bench for adc_conversor_arbiter. The shared conversor is modelled
// as o_conv_data ^ 14'h2000. Inputs change 1 time unit after the rising
// edge and outputs are sampled at the same point.
module tb_adc_conversor_arbiter;

  logic i_clock;
  logic i_reset;
  int   tests_run;
  int   tests_failed;

  adc_conversor_arbiter_if #(.CONVERSOR_DATA_SIZE(14), .OVERRUN_CNT_SIZE(16)) bus ();

  adc_conversor_arbiter #(.CONVERSOR_DATA_SIZE(14), .OVERRUN_CNT_SIZE(16)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  assign bus.i_conv_data = bus.o_conv_data ^ 14'h2000;

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_enable    = 1'b1;
    bus.i_ch1_data  = '0;
    bus.i_ch1_valid = 1'b0;
    bus.i_ch2_data  = '0;
    bus.i_ch2_valid = 1'b0;
    bus.i_ready     = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b0;
    tick();
    tick();
    i_reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset = 1'b0;
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_data !== 14'h0 || bus.o_channel !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%0b busy=%0b data=%h ch=%0b, want all 0",
               bus.o_valid, bus.o_busy, bus.o_data, bus.o_channel);
    end
    tests_run++;
    if (bus.o_overrun_ch1 !== 16'h0 || bus.o_overrun_ch2 !== 16'h0 || bus.o_conv_data !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_counters: ovr1=%h ovr2=%h conv=%h, want 0",
               bus.o_overrun_ch1, bus.o_overrun_ch2, bus.o_conv_data);
    end
    i_reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.i_ch1_data  = 14'h0000;
    bus.i_ch1_valid = 1'b1;
    tick();
    bus.i_ch1_valid = 1'b0;
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_pend: valid=%0b busy=%0b, want valid 0 busy 1", bus.o_valid, bus.o_busy);
    end
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 14'h2000 || bus.o_channel !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_out: valid=%0b data=%h ch=%0b, want 1 2000 0",
               bus.o_valid, bus.o_data, bus.o_channel);
    end
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_one_cycle: valid=%0b busy=%0b, want 0 0", bus.o_valid, bus.o_busy);
    end
  endtask

  task automatic do_tie(input logic [13:0] d1, input logic [13:0] d2, input logic ch2_first);
    logic [13:0] exp_a, exp_b;
    exp_a = (ch2_first ? d2 : d1) ^ 14'h2000;
    exp_b = (ch2_first ? d1 : d2) ^ 14'h2000;
    bus.i_ch1_data  = d1;
    bus.i_ch2_data  = d2;
    bus.i_ch1_valid = 1'b1;
    bus.i_ch2_valid = 1'b1;
    tick();
    bus.i_ch1_valid = 1'b0;
    bus.i_ch2_valid = 1'b0;
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== exp_a || bus.o_channel !== ch2_first) begin
      tests_failed++;
      $display("FAIL tie_first: valid=%0b data=%h ch=%0b, want 1 %h %0b",
               bus.o_valid, bus.o_data, bus.o_channel, exp_a, ch2_first);
    end
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== exp_b || bus.o_channel !== !ch2_first) begin
      tests_failed++;
      $display("FAIL tie_second: valid=%0b data=%h ch=%0b, want 1 %h %0b",
               bus.o_valid, bus.o_data, bus.o_channel, exp_b, !ch2_first);
    end
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_drain: valid=%0b, want 0", bus.o_valid);
    end
  endtask

  task automatic do_single(input logic ch2, input logic [13:0] d);
    bus.i_ch1_data  = d;
    bus.i_ch2_data  = d;
    bus.i_ch1_valid = !ch2;
    bus.i_ch2_valid = ch2;
    tick();
    bus.i_ch1_valid = 1'b0;
    bus.i_ch2_valid = 1'b0;
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== (d ^ 14'h2000) || bus.o_channel !== ch2) begin
      tests_failed++;
      $display("FAIL single_rr: valid=%0b data=%h ch=%0b, want 1 %h %0b",
               bus.o_valid, bus.o_data, bus.o_channel, d ^ 14'h2000, ch2);
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    do_tie(14'h3FFF, 14'h2000, 1'b0);   // ch1 1FFF then ch2 0000
    do_single(1'b0, 14'h0123);          // pointer now "last = ch1"
    do_tie(14'h0011, 14'h0022, 1'b1);   // ch2 first, ends on ch1
    do_tie(14'h0033, 14'h0044, 1'b1);
    do_single(1'b1, 14'h0555);          // pointer now "last = ch2"
    do_tie(14'h0066, 14'h0077, 1'b0);
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.i_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bus.i_ch1_data  = 14'(k);
      bus.i_ch1_valid = 1'b1;
      tick();
      if (k >= 2) begin
        tests_run++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 14'h2001 || bus.o_channel !== 1'b0) begin
          tests_failed++;
          $display("FAIL bp_hold_%0d: valid=%0b data=%h ch=%0b, want 1 2001 0",
                   k, bus.o_valid, bus.o_data, bus.o_channel);
        end
      end
    end
    bus.i_ch1_valid = 1'b0;
    tests_run++;
    if (bus.o_overrun_ch1 !== 16'd4 || bus.o_overrun_ch2 !== 16'd0) begin
      tests_failed++;
      $display("FAIL bp_overrun: ovr1=%0d ovr2=%0d, want 4 0", bus.o_overrun_ch1, bus.o_overrun_ch2);
    end
    bus.i_ready = 1'b1;
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 14'h2006 || bus.o_channel !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_freshest: valid=%0b data=%h ch=%0b, want 1 2006 0",
               bus.o_valid, bus.o_data, bus.o_channel);
    end
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_overrun_ch1 !== 16'd4) begin
      tests_failed++;
      $display("FAIL bp_drain: valid=%0b busy=%0b ovr1=%0d, want 0 0 4",
               bus.o_valid, bus.o_busy, bus.o_overrun_ch1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.i_ready     = 1'b0;
    bus.i_ch2_valid = 1'b1;
    // Edge 1 loads, edge 2 is granted while refilling, every later edge overruns.
    for (int n = 1; n <= 65541; n++) begin
      bus.i_ch2_data = 14'(n);
      tick();
      if (n == 65536) begin
        tests_run++;
        if (bus.o_overrun_ch2 !== 16'hFFFE) begin
          tests_failed++;
          $display("FAIL sat_before: ovr2=%h, want fffe", bus.o_overrun_ch2);
        end
      end
      if (n == 65537) begin
        tests_run++;
        if (bus.o_overrun_ch2 !== 16'hFFFF) begin
          tests_failed++;
          $display("FAIL sat_reach: ovr2=%h, want ffff", bus.o_overrun_ch2);
        end
      end
    end
    bus.i_ch2_valid = 1'b0;
    tests_run++;
    if (bus.o_overrun_ch2 !== 16'hFFFF || bus.o_overrun_ch1 !== 16'h0) begin
      tests_failed++;
      $display("FAIL sat_no_wrap: ovr2=%h ovr1=%h, want ffff 0", bus.o_overrun_ch2, bus.o_overrun_ch1);
    end
  endtask

  task automatic test_enable_flush();
    do_reset();
    bus.i_ready     = 1'b0;
    bus.i_ch1_data  = 14'h0001;
    bus.i_ch1_valid = 1'b1;
    tick();
    bus.i_ch1_data  = 14'h0002;
    bus.i_ch2_data  = 14'h0003;
    bus.i_ch2_valid = 1'b1;
    tick();
    bus.i_ch1_valid = 1'b0;
    bus.i_ch2_valid = 1'b0;
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 14'h2001 || bus.o_overrun_ch2 !== 16'd0) begin
      tests_failed++;
      $display("FAIL flush_setup: valid=%0b data=%h ovr2=%0d, want 1 2001 0",
               bus.o_valid, bus.o_data, bus.o_overrun_ch2);
    end
    bus.i_enable    = 1'b0;
    bus.i_ch1_data  = 14'h0004;
    bus.i_ch1_valid = 1'b1;
    tick();
    bus.i_enable    = 1'b1;
    bus.i_ch1_valid = 1'b0;
    bus.i_ready     = 1'b1;
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 14'h2001 || bus.o_overrun_ch1 !== 16'd0) begin
      tests_failed++;
      $display("FAIL flush_held: valid=%0b data=%h ovr1=%0d, want 1 2001 0",
               bus.o_valid, bus.o_data, bus.o_overrun_ch1);
    end
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle: valid=%0b busy=%0b, want 0 0", bus.o_valid, bus.o_busy);
    end
    tick();
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_overrun_ch1 !== 16'd0 || bus.o_overrun_ch2 !== 16'd0) begin
      tests_failed++;
      $display("FAIL flush_nothing: valid=%0b busy=%0b ovr1=%0d ovr2=%0d, want 0 0 0 0",
               bus.o_valid, bus.o_busy, bus.o_overrun_ch1, bus.o_overrun_ch2);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.i_ready     = 1'b0;
    bus.i_ch1_data  = 14'h0100;
    bus.i_ch1_valid = 1'b1;
    tick();
    bus.i_ch1_valid = 1'b0;
    bus.i_ch2_data  = 14'h0200;
    bus.i_ch2_valid = 1'b1;
    tick();
    tick();
    bus.i_ch2_valid = 1'b0;
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_overrun_ch2 !== 16'd1) begin
      tests_failed++;
      $display("FAIL rst_mid_setup: valid=%0b ovr2=%0d, want 1 1", bus.o_valid, bus.o_overrun_ch2);
    end
    #2;
    i_reset = 1'b0;
    #1;
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_data !== 14'h0 || bus.o_overrun_ch2 !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: valid=%0b busy=%0b data=%h ovr2=%0d, want 0 0 0 0",
               bus.o_valid, bus.o_busy, bus.o_data, bus.o_overrun_ch2);
    end
    tick();
    i_reset     = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_partial: valid=%0b busy=%0b, want 0 0", bus.o_valid, bus.o_busy);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_reset      = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enable_flush();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
